// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: Moore FSM sequencing fetch/decode/exec/mem/writeback with memory timeout.
// Define MCU_ILLEGAL_TRAP_EN to trap unknown instructions in a sticky TRAP state.
module multicycle_control_unit #(
  parameter int OPCODE_W     = 6,
  parameter int FUNCT_W      = 5,
  parameter int ALUOP_W      = 5,
  parameter int MEM_MAX_WAIT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                instr_valid,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FUNCT_W-1:0]  funct,
  input  logic                mem_ready,
  output logic                ir_w,
  output logic                pc_w,
  output logic [1:0]          reg_select,
  output logic                reg_w,
  output logic                mem_r,
  output logic                mem_w,
  output logic [1:0]          mem_to_reg,
  output logic                ALUsrc,
  output logic [ALUOP_W-1:0]  ALUop,
  output logic                comp_sel,
  output logic                busy,
  output logic                mem_err,
  output logic                illegal
);
  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXEC, MEM, WB, RETIRE
`ifdef MCU_ILLEGAL_TRAP_EN
    , TRAP
`endif
  } state_t;
`ifdef MCU_ILLEGAL_TRAP_EN
  localparam state_t BAD = TRAP;
`else
  localparam state_t BAD = RETIRE;
`endif
  state_t state, state_n;
  logic [OPCODE_W-1:0] op_q;
  logic [FUNCT_W-1:0] fn_q;
  logic [7:0] wait_cnt;
  logic mem_err_q, timeout, act;
  logic known, is_lw, is_sw, src, cmp;
  logic [4:0] alu_code;
  assign timeout = wait_cnt == 8'(MEM_MAX_WAIT - 1);
  assign act = state inside {EXEC, MEM, WB};
  always_comb begin
    known = 1'b1;
    is_lw = 1'b0;
    is_sw = 1'b0;
    src = 1'b0;
    cmp = 1'b0;
    alu_code = 5'd0;
    case (int'(op_q))
      0: if (int'(fn_q) == 0) alu_code = 5'd1;
         else if (int'(fn_q) == 1) {alu_code, cmp} = {5'd5, 1'b1};
         else known = 1'b0;
      1: {alu_code, src} = {5'd1, 1'b1};
      2: {alu_code, src, cmp} = {5'd5, 1'b1, 1'b1};
      3: if (int'(fn_q) == 0) alu_code = 5'd2;
         else if (int'(fn_q) == 1) alu_code = 5'd3;
         else known = 1'b0;
      4: {alu_code, src, is_lw} = {5'd1, 1'b1, 1'b1};
      5: {alu_code, src, is_sw} = {5'd1, 1'b1, 1'b1};
      default: known = 1'b0;
    endcase
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = instr_valid ? FETCH : IDLE;
      FETCH:   state_n = DECODE;
      DECODE:  state_n = EXEC;
      EXEC:    state_n = !known ? BAD : (is_lw | is_sw) ? MEM : WB;
      MEM:     state_n = mem_ready ? (is_lw ? WB : RETIRE) : timeout ? RETIRE : MEM;
      WB:      state_n = RETIRE;
      RETIRE:  state_n = instr_valid ? FETCH : IDLE;
`ifdef MCU_ILLEGAL_TRAP_EN
      TRAP:    state_n = TRAP;
`endif
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op_q <= '0;
      fn_q <= '0;
      wait_cnt <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state <= state_n;
      if (state == DECODE) {op_q, fn_q} <= {opcode, funct};
      // counter stays at zero outside MEM, so every MEM entry starts fresh
      wait_cnt <= (state == MEM && !mem_ready) ? wait_cnt + 8'd1 : 8'd0;
      mem_err_q <= state == MEM && !mem_ready && timeout;
    end
  end
`ifdef MCU_ILLEGAL_TRAP_EN
  logic illegal_q;
  always_ff @(posedge clk) begin
    if (rst) illegal_q <= 1'b0;
    else illegal_q <= illegal_q | (state_n == TRAP);
  end
  assign illegal = illegal_q & !rst;
`else
  assign illegal = 1'b0;
`endif
  assign mem_err = mem_err_q & !rst;
  always_comb begin
    {ir_w, pc_w, reg_w, mem_r, mem_w, ALUsrc, comp_sel, busy} = '0;
    reg_select = 2'b00;
    mem_to_reg = 2'b00;
    ALUop = '0;
    if (!rst) begin
      ir_w = state == FETCH;
      pc_w = state == RETIRE;
      busy = state != IDLE;
      ALUop = act ? ALUOP_W'(alu_code) : '0;
      ALUsrc = act & src;
      comp_sel = act & cmp;
      mem_r = state == MEM && is_lw;
      mem_w = state == MEM && is_sw;
      reg_w = state == WB && known;
      reg_select = (state == WB && is_lw) ? 2'b01 : 2'b00;
      mem_to_reg = state != WB ? 2'b00 : is_lw ? 2'b01 : 2'b10;
    end
  end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: scoreboard bench; driver pushes per-instruction expectations, monitor checks each retirement.
module tb_multicycle_control_unit;
  localparam int MAXW = 15;
  logic clk = 1'b0, rst = 1'b1, instr_valid = 1'b0, mem_ready = 1'b0;
  logic [5:0] opcode = '0;
  logic [4:0] funct = '0, ALUop;
  logic ir_w, pc_w, reg_w, mem_r, mem_w, ALUsrc, comp_sel, busy, mem_err, illegal;
  logic [1:0] reg_select, mem_to_reg;
  int errors = 0, checks = 0;
  typedef struct {int lat; int regw; int memr; int memw; int err; int alu; int src; int cmp; int rs; int mtr;} exp_t;
  exp_t q[$];
  multicycle_control_unit dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .opcode(opcode), .funct(funct),
    .mem_ready(mem_ready), .ir_w(ir_w), .pc_w(pc_w), .reg_select(reg_select), .reg_w(reg_w),
    .mem_r(mem_r), .mem_w(mem_w), .mem_to_reg(mem_to_reg), .ALUsrc(ALUsrc), .ALUop(ALUop),
    .comp_sel(comp_sel), .busy(busy), .mem_err(mem_err), .illegal(illegal)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
  task automatic chk(string nm, int got, int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, want);
    end
  endtask
  // instruction-level view: class from the decode table, latency from the state path length
  function automatic exp_t model(int op, int fn, int n);
    exp_t e;
    int kind, m;
    e = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    kind = 3;
    case (op)
      0: if (fn == 0) begin kind = 0; e.alu = 1; end
         else if (fn == 1) begin kind = 0; e.alu = 5; e.cmp = 1; end
      1: begin kind = 0; e.alu = 1; e.src = 1; end
      2: begin kind = 0; e.alu = 5; e.src = 1; e.cmp = 1; end
      3: if (fn == 0) begin kind = 0; e.alu = 2; end
         else if (fn == 1) begin kind = 0; e.alu = 3; end
      4: begin kind = 1; e.alu = 1; e.src = 1; end
      5: begin kind = 2; e.alu = 1; e.src = 1; end
      default: ;
    endcase
    m = n >= MAXW ? MAXW : n + 1;
    case (kind)
      0: begin e.lat = 5; e.regw = 1; e.rs = 0; e.mtr = 2; end
      1: begin
        e.memr = m;
        if (n >= MAXW) begin e.lat = 4 + m; e.err = 1; end
        else begin e.lat = 5 + m; e.regw = 1; e.rs = 1; e.mtr = 1; end
      end
      2: begin e.memw = m; e.lat = 4 + m; e.err = n >= MAXW ? 1 : 0; end
      default: e.lat = 4;
    endcase
    return e;
  endfunction
  int cyc, nregw, nmr, nmw, nerr, wbc, o_alu, o_src, o_cmp, o_rs, o_mtr;
  bit act = 0, stray;
  always @(negedge clk) begin
    exp_t e;
    if (rst) act = 0;
    else begin
      if (ir_w) begin
        act = 1; cyc = 1; nregw = 0; nmr = 0; nmw = 0; nerr = 0; wbc = 0; stray = 0;
        o_alu = 0; o_src = 0; o_cmp = 0; o_rs = 0; o_mtr = 0;
      end else if (act) cyc++;
      if (act) begin
        nregw += int'(reg_w); nmr += int'(mem_r); nmw += int'(mem_w); nerr += int'(mem_err);
        if (cyc == 3) begin o_alu = int'(ALUop); o_src = int'(ALUsrc); o_cmp = int'(comp_sel); end
        if (reg_w) begin o_rs = int'(reg_select); o_mtr = int'(mem_to_reg); wbc = cyc; end
        if (!busy || ((cyc < 3 || pc_w) && (ALUop != 0 || ALUsrc || comp_sel)) ||
            (!reg_w && (reg_select != 0 || mem_to_reg != 0)) || (pc_w && (mem_r || mem_w))) stray = 1;
        if (pc_w) begin
          act = 0;
          if (q.size() == 0) chk("retire_without_issue", 1, 0);
          else begin
            e = q.pop_front();
            chk("latency", cyc, e.lat);
            chk("reg_w_cycles", nregw, e.regw);
            chk("mem_r_cycles", nmr, e.memr);
            chk("mem_w_cycles", nmw, e.memw);
            chk("mem_err_pulses", nerr, e.err);
            chk("exec_aluop", o_alu, e.alu);
            chk("exec_alusrc", o_src, e.src);
            chk("exec_comp_sel", o_cmp, e.cmp);
            chk("stray_output", int'(stray), 0);
            if (e.regw == 1) begin
              chk("wb_cycle", wbc, e.lat - 1);
              chk("wb_reg_select", o_rs, e.rs);
              chk("wb_mem_to_reg", o_mtr, e.mtr);
            end
          end
        end
      end
    end
  end
  // called at a negedge while IDLE or RETIRE; returns at the RETIRE negedge (or after the idle gap)
  task automatic issue(int op, int fn, int n, int gap);
    int t, idx;
    q.push_back(model(op, fn, n));
    opcode = 6'(op); funct = 5'(fn); instr_valid = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!ir_w && t < 20);
    if (!ir_w) begin chk("fetch_timeout", 0, 1); return; end
    instr_valid = 1'($urandom); mem_ready = 1'($urandom);
    @(negedge clk);
    instr_valid = 1'($urandom);
    @(negedge clk);
    opcode = 6'($urandom); funct = 5'($urandom);
    idx = 0; t = 0;
    while (!pc_w && t < 60) begin
      if (mem_r || mem_w) begin mem_ready = idx == n; idx++; end
      else mem_ready = 1'($urandom);
      instr_valid = 1'($urandom);
      @(negedge clk); t++;
    end
    if (!pc_w) begin chk("retire_timeout", 0, 1); return; end
    instr_valid = gap == 0;
    repeat (gap) begin @(negedge clk); chk("idle_busy", int'(busy), 0); end
  endtask
  initial begin
    int k, op, fn;
    exp_t tmp;
    repeat (2) @(negedge clk);
    chk("reset_outputs_zero", int'({ir_w, pc_w, reg_select, reg_w, mem_r, mem_w, mem_to_reg,
        ALUsrc, ALUop, comp_sel, busy, mem_err, illegal}), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", int'({busy, ir_w, pc_w}), 0);
    opcode = 6'd4; funct = '0; instr_valid = 1'b1; mem_ready = 1'b0; k = 0;
    for (int i = 0; i < 30 && k < 2; i++) begin @(negedge clk); if (mem_r) k++; end
    chk("reached_second_mem", k, 2);
    rst = 1'b1; instr_valid = 1'b0;
    @(negedge clk);
    chk("reset_mid_mem_mem_r", int'(mem_r), 0);
    chk("reset_mid_mem_busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("after_reset_idle", int'({busy, mem_r, mem_err, reg_w}), 0);
    issue(0, 0, 0, 0);
    issue(4, 0, 3, 0);
    issue(5, 0, 40, 0);
    issue(4, 0, 14, 0);
    issue(4, 0, 15, 0);
`ifndef MCU_ILLEGAL_TRAP_EN
    issue(63, 0, 0, 0);
`endif
    issue(1, 0, 0, 3);
    issue(2, 0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 7);
      if ($urandom_range(0, 9) == 0) op = 63;
      fn = $urandom_range(0, 3);
      tmp = model(op, fn, 0);
`ifdef MCU_ILLEGAL_TRAP_EN
      if (tmp.lat == 4) begin op = 0; fn = 0; end
`endif
      issue(op, fn, $urandom_range(0, 17), $urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0);
    end
    instr_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
`ifdef MCU_ILLEGAL_TRAP_EN
    opcode = 6'd63; instr_valid = 1'b1;
    repeat (12) @(negedge clk);
    chk("trap_illegal", int'(illegal), 1);
    chk("trap_busy", int'(busy), 1);
    chk("trap_strobes", int'({pc_w, reg_w, mem_r, mem_w}), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0; instr_valid = 1'b0;
    @(negedge clk);
    chk("trap_cleared", int'({illegal, busy}), 0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
